// File: rtl/ram_ctrl_rmw_pkg.sv
// Shared constants for the opcode-bus scratch RAM: bus widths, block select,
// operation codes and controller state encodings.
package ram_ctrl_rmw_pkg;

    localparam int RAM_DATA_WIDTH = 16;
    localparam int RAM_ADDR_WIDTH = 8;
    localparam logic [3:0] RAM_OP_NIBBLE_DEFAULT = 4'h4;

    localparam logic [3:0] RAM_WRITE = 4'h1;
    localparam logic [3:0] RAM_READ  = 4'h2;
    localparam logic [3:0] RAM_ADD   = 4'h3;
    localparam logic [3:0] RAM_CLEAR = 4'h4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RMW   = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

endpackage

// File: rtl/ram_ctrl_rmw_if.sv
// Opcode/operand command bus with valid/ready handshake and read-result strobe.
interface ram_ctrl_rmw_if
    import ram_ctrl_rmw_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] opcode;
    logic [DATA_WIDTH-1:0] operand;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_valid;
    logic                  carry;
    logic                  busy;

    modport master (
        output opcode, operand, write_data, cmd_valid,
        input  cmd_ready, read_data, read_valid, carry, busy
    );

    modport slave (
        input  opcode, operand, write_data, cmd_valid,
        output cmd_ready, read_data, read_valid, carry, busy
    );
endinterface

// File: rtl/ram_sp_array.sv
// Plain single-port storage: synchronous write, registered read-first output.
module ram_sp_array #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_reg [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= wdata;
        end
        rdata_reg <= mem_reg[addr];
    end

    assign rdata = rdata_reg;
endmodule

// File: rtl/ram_ctrl_rmw.sv
// Opcode-decoded scratch RAM controller: write, read, atomic add and clear-all
// sweep around a single-port array, with a registered result strobe.
module ram_ctrl_rmw
    import ram_ctrl_rmw_pkg::*;
#(
    parameter int         DATA_WIDTH    = RAM_DATA_WIDTH,
    parameter int         ADDR_WIDTH    = RAM_ADDR_WIDTH,
    parameter logic [3:0] RAM_OP_NIBBLE = RAM_OP_NIBBLE_DEFAULT
) (
    input logic           clk,
    input logic           reset,
    ram_ctrl_rmw_if.slave bus
);
    logic [1:0]            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] addend_reg;
    logic [ADDR_WIDTH-1:0] sweep_reg;
    logic                  valid_reg;
    logic                  add_sel_reg;
    logic [DATA_WIDTH-1:0] sum_reg;
    logic                  carry_reg;

    logic [3:0]            op;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic                  accept;
    logic [DATA_WIDTH:0]   sum;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  unused_bits;

    assign op          = bus.opcode[11:8];
    assign addr_in     = bus.operand[ADDR_WIDTH-1:0];
    assign accept      = bus.cmd_valid && (state_reg == ST_IDLE)
                         && (bus.opcode[15:12] == RAM_OP_NIBBLE);
    assign sum         = {1'b0, ram_rdata} + {1'b0, addend_reg};
    assign unused_bits = ^{bus.opcode[7:0], bus.operand[DATA_WIDTH-1:ADDR_WIDTH]};

    // Port mux; writes are suppressed during reset so an interrupted ADD or
    // CLEAR leaves the remaining memory untouched.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = addr_in;
        ram_wdata = bus.write_data;
        case (state_reg)
            ST_IDLE:  ram_we = accept && (op == RAM_WRITE);
            ST_RMW: begin
                ram_we    = 1'b1;
                ram_addr  = addr_reg;
                ram_wdata = sum[DATA_WIDTH-1:0];
            end
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_addr  = sweep_reg;
                ram_wdata = '0;
            end
            default:  ram_we = 1'b0;
        endcase
        ram_we = ram_we && reset;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept && (op == RAM_ADD))   state_next = ST_RMW;
                if (accept && (op == RAM_CLEAR)) state_next = ST_CLEAR;
            end
            ST_RMW:   state_next = ST_IDLE;
            ST_CLEAR: if (sweep_reg == '1) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= ST_IDLE;
            valid_reg   <= 1'b0;
            add_sel_reg <= 1'b0;
            sum_reg     <= '0;
            carry_reg   <= 1'b0;
            sweep_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            valid_reg   <= (accept && (op == RAM_READ)) || (state_reg == ST_RMW);
            add_sel_reg <= (state_reg == ST_RMW);
            sum_reg     <= (state_reg == ST_RMW) ? sum[DATA_WIDTH-1:0] : '0;
            carry_reg   <= (state_reg == ST_RMW) && sum[DATA_WIDTH];
            if (accept && (op == RAM_CLEAR)) begin
                sweep_reg <= '0;
            end else if (state_reg == ST_CLEAR) begin
                sweep_reg <= sweep_reg + 1'b1;
            end
            if (accept) begin
                addr_reg   <= addr_in;
                addend_reg <= bus.write_data;
            end
        end
    end

    ram_sp_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // READ data comes straight from the array's output register; ADD results
    // from sum_reg. Both are forced to zero outside the strobe.
    assign bus.read_data  = !valid_reg ? '0 : (add_sel_reg ? sum_reg : ram_rdata);
    assign bus.read_valid = valid_reg;
    assign bus.carry      = carry_reg;
    assign bus.cmd_ready  = (state_reg == ST_IDLE);
    assign bus.busy       = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_ram_ctrl_rmw.sv
// Directed bench for ram_ctrl_rmw at ADDR_WIDTH=4 with hand-computed expectations.
module tb_ram_ctrl_rmw;
    logic clk;
    logic reset;
    int   assert_count;
    int   fail_count;

    ram_ctrl_rmw_if #(.DATA_WIDTH(16)) bus ();

    ram_ctrl_rmw #(
        .DATA_WIDTH    (16),
        .ADDR_WIDTH    (4),
        .RAM_OP_NIBBLE (4'h4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] opc, input logic [3:0] a, input logic [15:0] d);
        bus.opcode     = opc;
        bus.operand    = {12'h0, a};
        bus.write_data = d;
        bus.cmd_valid  = 1'b1;
    endtask

    task automatic idle_bus();
        bus.cmd_valid  = 1'b0;
        bus.opcode     = 16'h0;
        bus.operand    = 16'h0;
        bus.write_data = 16'h0;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d);
        drive(16'h4100, a, d);
        tick();
        idle_bus();
        $display("WRITE addr=%0d data=%h", a, d);
    endtask

    task automatic do_read(input string tag, input logic [3:0] a, input logic [15:0] exp);
        drive(16'h4200, a, 16'h0);
        tick();
        idle_bus();
        check({tag, "_valid"}, {31'h0, bus.read_valid}, 32'h1);
        check({tag, "_data"}, {16'h0, bus.read_data}, {16'h0, exp});
        check({tag, "_carry"}, {31'h0, bus.carry}, 32'h0);
        $display("READ  addr=%0d data=%h expected=%h", a, bus.read_data, exp);
    endtask

    initial begin
        int n;
        assert_count = 0;
        fail_count   = 0;
        reset        = 1'b0;
        idle_bus();

        // Reset state
        tick();
        tick();
        check("rst_ready", {31'h0, bus.cmd_ready}, 32'h1);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_valid", {31'h0, bus.read_valid}, 32'h0);
        check("rst_data", {16'h0, bus.read_data}, 32'h0);
        check("rst_carry", {31'h0, bus.carry}, 32'h0);
        reset = 1'b1;
        tick();

        // WRITE then READ, strobe lasts one cycle
        do_write(4'd3, 16'hBEEF);
        do_read("rd3", 4'd3, 16'hBEEF);
        tick();
        check("rd3_strobe_end", {31'h0, bus.read_valid}, 32'h0);
        check("rd3_data_zero", {16'h0, bus.read_data}, 32'h0);

        // Back-to-back WRITE/READ same address
        drive(16'h4100, 4'd7, 16'h0001);
        check("b2b_ready_w", {31'h0, bus.cmd_ready}, 32'h1);
        tick();
        check("b2b_ready_r", {31'h0, bus.cmd_ready}, 32'h1);
        drive(16'h4200, 4'd7, 16'h0000);
        tick();
        idle_bus();
        check("b2b_valid", {31'h0, bus.read_valid}, 32'h1);
        check("b2b_data", {16'h0, bus.read_data}, 32'h0001);
        check("b2b_ready_after", {31'h0, bus.cmd_ready}, 32'h1);
        $display("B2B   addr=7 write=0001 read=%h", bus.read_data);

        // ADD with wrap and carry
        do_write(4'd5, 16'hFFFE);
        drive(16'h4300, 4'd5, 16'h0003);
        tick();
        idle_bus();
        check("add_ready_low", {31'h0, bus.cmd_ready}, 32'h0);
        check("add_busy", {31'h0, bus.busy}, 32'h1);
        check("add_no_early_valid", {31'h0, bus.read_valid}, 32'h0);
        tick();
        check("add_valid", {31'h0, bus.read_valid}, 32'h1);
        check("add_data", {16'h0, bus.read_data}, 32'h0001);
        check("add_carry", {31'h0, bus.carry}, 32'h1);
        check("add_ready_back", {31'h0, bus.cmd_ready}, 32'h1);
        $display("ADD   addr=5 FFFE+0003 -> %h carry=%0b", bus.read_data, bus.carry);
        tick();
        check("add_strobe_end", {31'h0, bus.read_valid}, 32'h0);
        check("add_carry_end", {31'h0, bus.carry}, 32'h0);
        do_read("rd5", 4'd5, 16'h0001);

        // ADD without carry
        do_write(4'd9, 16'h0100);
        drive(16'h4300, 4'd9, 16'h0023);
        tick();
        idle_bus();
        tick();
        check("add2_data", {16'h0, bus.read_data}, 32'h0123);
        check("add2_carry", {31'h0, bus.carry}, 32'h0);
        $display("ADD   addr=9 0100+0023 -> %h carry=%0b", bus.read_data, bus.carry);
        tick();

        // CLEAR sweep
        for (int i = 0; i < 16; i++) do_write(i[3:0], 16'hA5A5);
        drive(16'h4400, 4'd0, 16'h0);
        tick();
        idle_bus();
        n = 0;
        while (bus.busy && n < 100) begin
            if (bus.cmd_ready || bus.read_valid) check("clr_ready_valid_low", 32'h1, 32'h0);
            n++;
            tick();
        end
        check("clr_busy_cycles", n, 32'd16);
        $display("CLEAR busy for %0d cycles", n);
        for (int i = 0; i < 16; i++) do_read($sformatf("clr_rd%0d", i), i[3:0], 16'h0000);

        // Reset mid-CLEAR after five sweep cycles
        for (int i = 0; i < 16; i++) do_write(i[3:0], 16'h1234);
        drive(16'h4400, 4'd0, 16'h0);
        tick();
        idle_bus();
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mclr_ready", {31'h0, bus.cmd_ready}, 32'h1);
        check("mclr_busy", {31'h0, bus.busy}, 32'h0);
        $display("RESET during CLEAR after 5 cycles");
        for (int i = 0; i < 16; i++)
            do_read($sformatf("mclr_rd%0d", i), i[3:0], (i < 5) ? 16'h0000 : 16'h1234);

        // Non-selected, unknown and invalid commands
        do_write(4'd2, 16'h5A5A);
        drive(16'h3100, 4'd2, 16'hDEAD);
        tick();
        idle_bus();
        check("nsel_valid", {31'h0, bus.read_valid}, 32'h0);
        $display("NOSEL opcode=3100 addr=2");
        drive(16'h4F00, 4'd2, 16'hDEAD);
        check("unk_ready", {31'h0, bus.cmd_ready}, 32'h1);
        tick();
        idle_bus();
        check("unk_valid", {31'h0, bus.read_valid}, 32'h0);
        check("unk_busy", {31'h0, bus.busy}, 32'h0);
        $display("UNK   opcode=4F00 addr=2");
        bus.opcode    = 16'h4200;
        bus.operand   = 16'h0002;
        bus.cmd_valid = 1'b0;
        tick();
        idle_bus();
        check("novalid_read", {31'h0, bus.read_valid}, 32'h0);
        $display("READ  addr=2 with cmd_valid=0");
        do_read("rd2", 4'd2, 16'h5A5A);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule

// File: doc/ram_ctrl_rmw.md
Name: ram_ctrl_rmw

Overview:
Parametrised successor to the processor's opcode-decoded scratch RAM. It is a single-port synchronous RAM driven by the shared opcode/operand bus, with a valid/ready command handshake. It supports write, read, atomic read-modify-write add, and a multi-cycle clear-all sweep, and returns read data with an explicit valid strobe instead of tri-stating. It sits beside the ALU on the processor's opcode bus and holds counters and accumulators for puzzle kernels.

Parameters:
DATA_WIDTH, 16, width of each RAM word and of the opcode, operand and write_data buses.
ADDR_WIDTH, 8, address bits taken from operand[ADDR_WIDTH-1:0]. Depth is 2**ADDR_WIDTH.
RAM_OP_NIBBLE, 4'h4, value of opcode[15:12] that selects this block.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-low reset. 0 resets the block; sampled on the clk rising edge.
opcode  in  DATA_WIDTH  [15:12] block select; [11:8] operation (1=WRITE, 2=READ, 3=ADD, 4=CLEAR); other bits ignored.
operand  in  DATA_WIDTH  address in [ADDR_WIDTH-1:0]; upper bits ignored.
write_data  in  DATA_WIDTH  data for WRITE; addend for ADD.
cmd_valid  in  1  command present this cycle.
cmd_ready  out  1  block can accept a command.
read_data  out  DATA_WIDTH  result word; 0 whenever read_valid=0.
read_valid  out  1  one-cycle strobe qualifying read_data and carry.
carry  out  1  carry-out of the ADD result; 0 except on an ADD result strobe.
busy  out  1  high while in the RMW or CLEAR state.

Behaviour:
- Accept condition: cmd_valid & cmd_ready & opcode[15:12]==RAM_OP_NIBBLE. When not accepted, the RAM and all outputs hold or idle.
- Unknown operation codes (0, 5-15) are accepted and ignored. They produce no read_valid and leave the RAM unchanged.
- FSM states:
  - IDLE: cmd_ready=1.
  - RMW: one cycle, cmd_ready=0.
  - CLEAR: 2**ADDR_WIDTH cycles, cmd_ready=0.
- WRITE: on the accept edge, mem[addr] <= write_data. No read_valid. Stays in IDLE.
- READ: on the accept edge, read_data <= mem[addr] and read_valid <= 1. Latency is 1 cycle. Stays in IDLE.
- Back-to-back commands:
  - A WRITE accepted in cycle N followed by a READ of the same address in cycle N+1 returns the new data.
  - READ and WRITE may each issue every cycle.
- ADD:
  - Accept edge: latch addr, write_data and mem[addr]; go to RMW.
  - RMW edge: sum = old + addend (DATA_WIDTH+1 bits); mem[addr] <= sum[DATA_WIDTH-1:0]; read_data <= sum[DATA_WIDTH-1:0]; carry <= sum[DATA_WIDTH]; read_valid <= 1; go to IDLE.
  - Latency is 2 cycles from accept to read_valid.
  - Arithmetic wraps modulo 2**DATA_WIDTH.
- CLEAR:
  - Accept edge: sweep counter <= 0; go to CLEAR.
  - Each CLEAR cycle: mem[counter] <= 0; counter++.
  - After the write to address 2**ADDR_WIDTH-1, go to IDLE. cmd_ready returns on the following cycle.
  - No read_valid is produced.
- read_valid, read_data and carry are registered. They are high or non-zero for exactly one cycle per READ or ADD, and are 0 otherwise.
- Reset (reset=0 at a clk edge):
  - State <= IDLE; read_valid, read_data, carry <= 0; sweep counter <= 0.
  - In the following cycle: cmd_ready=1, busy=0.
  - RAM contents are not initialised by reset. Only CLEAR zeros them.
- Reset mid-ADD: the write-back does not occur and memory is unchanged.
- Reset mid-CLEAR: locations already swept remain 0; the rest are unchanged.
- Commands presented while cmd_ready=0 are not accepted. The producer holds cmd_valid and the command until accepted.

Decomposition:
- Shared package/defines: DATA_WIDTH default; RAM_OP_NIBBLE; operation codes RAM_WRITE=4'h1, RAM_READ=4'h2, RAM_ADD=4'h3, RAM_CLEAR=4'h4; FSM state encodings IDLE/RMW/CLEAR.
- One sub-module: ram_sp_array. It is the plain single-port storage with synchronous write and registered read, parametrised by DATA_WIDTH and ADDR_WIDTH, so synthesis infers block RAM.
- ram_ctrl_rmw holds the decode, FSM, adder, sweep counter and output registers.

Test Plan:
- Reset then WRITE/READ: hold reset=0 for 2 cycles, release; WRITE 16'hBEEF to addr 3, then READ addr 3 -> read_valid=1 exactly one cycle after the READ is accepted, read_data=16'hBEEF, carry=0.
- Back-to-back hazard: WRITE 16'h0001 to addr 7 in cycle N, READ addr 7 in cycle N+1 -> read_data=16'h0001 at N+2; cmd_ready stays 1 throughout.
- ADD with wrap: WRITE 16'hFFFE to addr 5; ADD 16'h0003 to addr 5 -> cmd_ready=0 for 1 cycle, read_valid 2 cycles after accept, read_data=16'h0001, carry=1; a subsequent READ of addr 5 returns 16'h0001.
- CLEAR with ADDR_WIDTH=4: fill addresses 0-15 with 16'hA5A5; issue CLEAR -> busy=1 and cmd_ready=0 for 16 cycles, no read_valid; READ of each address returns 0.
- Reset mid-CLEAR (ADDR_WIDTH=4, all addresses 16'h1234): assert reset=0 after 5 CLEAR cycles -> addresses 0-4 read 0, addresses 5-15 read 16'h1234; cmd_ready=1 in the first cycle after reset releases.
- Non-selected and unknown opcodes: opcode 16'h3100 with cmd_valid=1 -> memory unchanged, no read_valid; opcode 16'h4F00 -> accepted with cmd_ready=1, no read_valid, memory unchanged; READ presented with cmd_valid=0 -> no read_valid.
